// File: rtl/gsm_cell_release_ctrl.sv
// rtl/gsm_cell_release_ctrl.sv - GSM cell release scheduler: per-cell reader masks, round-robin release arbiter, free-address FIFO
module gsm_cell_release_ctrl #(
  parameter int MWIDTH = 4,
  parameter int AWIDTH = 7
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     i_alloc_valid,
  input  logic [AWIDTH-1:0]        i_alloc_addr,
  input  logic [MWIDTH-1:0]        i_alloc_mcast,
  input  logic [MWIDTH-1:0]        i_rel_req,
  input  logic [MWIDTH*AWIDTH-1:0] i_rel_addr,
  output logic [MWIDTH-1:0]        o_rel_ack,
  input  logic                     i_hmp_rd,
  output logic                     o_hmp_valid,
  output logic [AWIDTH-1:0]        o_hmp_addr,
  output logic                     o_bf_free_flag,
  output logic [AWIDTH:0]          o_free_cnt,
  output logic                     o_err
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int PW    = (MWIDTH > 1) ? $clog2(MWIDTH) : 1;

  logic [MWIDTH-1:0] mask [DEPTH];
  logic [AWIDTH-1:0] fifo [DEPTH];
  logic [AWIDTH-1:0] rd_ptr, wr_ptr;
  logic [AWIDTH:0]   cnt;
  logic [PW-1:0]     rr_ptr;
  logic              flag_q;

  logic              gnt_valid;
  logic [PW-1:0]     gnt_port;
  logic [MWIDTH-1:0] ack;
  logic [AWIDTH-1:0] rel_addr;
  logic [MWIDTH-1:0] cur_mask, new_mask;
  logic              bit_set, alloc_ok, collide, rel_write, push, push_ok, pop_ok;
  logic              empty, full, err;

  // rr_ptr holds the first port to search, i.e. last grant + 1
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = '0;
    ack       = '0;
    for (int i = 0; i < MWIDTH; i++) begin
      if (!gnt_valid && i_rel_req[(int'(rr_ptr) + i) % MWIDTH]) begin
        gnt_valid = 1'b1;
        gnt_port  = PW'((int'(rr_ptr) + i) % MWIDTH);
      end
    end
    if (clr) gnt_valid = 1'b0;
    if (gnt_valid) ack[gnt_port] = 1'b1;
  end

  always_comb begin
    rel_addr  = i_rel_addr[int'(gnt_port)*AWIDTH +: AWIDTH];
    cur_mask  = mask[rel_addr];
    bit_set   = cur_mask[gnt_port];
    new_mask  = cur_mask & ~(MWIDTH'(1) << gnt_port);
    alloc_ok  = i_alloc_valid && (i_alloc_mcast != '0);
    collide   = gnt_valid && alloc_ok && (i_alloc_addr == rel_addr);
    rel_write = gnt_valid && bit_set && !collide;
    push      = rel_write && (new_mask == '0);
    empty     = (cnt == '0);
    full      = cnt[AWIDTH];
    pop_ok    = i_hmp_rd && !empty;
    push_ok   = push && (!full || pop_ok);
    err       = !clr && ((i_alloc_valid && i_alloc_mcast == '0) ||
                         (alloc_ok && mask[i_alloc_addr] != '0) ||
                         (gnt_valid && !bit_set) || collide ||
                         (i_hmp_rd && empty) || (push && !push_ok));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mask[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
      flag_q <= 1'b0;
    end else begin
      // Alloc is written last so it wins over a release to the same cell
      if (rel_write) mask[rel_addr] <= new_mask;
      if (alloc_ok) mask[i_alloc_addr] <= i_alloc_mcast;
      if (gnt_valid) rr_ptr <= (int'(gnt_port) == MWIDTH - 1) ? '0 : gnt_port + PW'(1);
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      flag_q <= push_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && push_ok) fifo[wr_ptr] <= rel_addr;
  end

  assign o_rel_ack      = ack;
  assign o_hmp_valid    = !empty;
  assign o_hmp_addr     = empty ? '0 : fifo[rd_ptr];
  assign o_bf_free_flag = flag_q;
  assign o_free_cnt     = cnt;
  assign o_err          = err;

endmodule

// File: tb/tb_gsm_cell_release_ctrl.sv
// tb/tb_gsm_cell_release_ctrl.sv - directed bench for gsm_cell_release_ctrl with free-address scoreboard
module tb_gsm_cell_release_ctrl;
  localparam int MW = 4;
  localparam int AW = 7;

  logic             clk = 1'b0;
  logic             clr;
  logic             i_alloc_valid;
  logic [AW-1:0]    i_alloc_addr;
  logic [MW-1:0]    i_alloc_mcast;
  logic [MW-1:0]    i_rel_req;
  logic [MW*AW-1:0] i_rel_addr;
  logic [MW-1:0]    o_rel_ack;
  logic             i_hmp_rd;
  logic             o_hmp_valid;
  logic [AW-1:0]    o_hmp_addr;
  logic             o_bf_free_flag;
  logic [AW:0]      o_free_cnt;
  logic             o_err;

  logic [AW-1:0] exp_q[$];
  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gsm_cell_release_ctrl #(.MWIDTH(MW), .AWIDTH(AW)) dut (
    .clk(clk), .clr(clr),
    .i_alloc_valid(i_alloc_valid), .i_alloc_addr(i_alloc_addr), .i_alloc_mcast(i_alloc_mcast),
    .i_rel_req(i_rel_req), .i_rel_addr(i_rel_addr), .o_rel_ack(o_rel_ack),
    .i_hmp_rd(i_hmp_rd), .o_hmp_valid(o_hmp_valid), .o_hmp_addr(o_hmp_addr),
    .o_bf_free_flag(o_bf_free_flag), .o_free_cnt(o_free_cnt), .o_err(o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_in();
    i_alloc_valid = 1'b0;
    i_alloc_addr  = '0;
    i_alloc_mcast = '0;
    i_rel_req     = '0;
    i_rel_addr    = '0;
    i_hmp_rd      = 1'b0;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic req(input int p, input int a);
    i_rel_req[p] = 1'b1;
    i_rel_addr[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic set_alloc(input int a, input int m);
    i_alloc_valid = 1'b1;
    i_alloc_addr  = a[AW-1:0];
    i_alloc_mcast = m[MW-1:0];
  endtask

  task automatic alloc(input int a, input int m);
    set_alloc(a, m);
    mid();
    chk("alloc_err", 32'(o_err), 0);
    edge_step();
    clear_in();
  endtask

  task automatic pop_chk();
    i_hmp_rd = 1'b1;
    mid();
    chk("pop_valid", 32'(o_hmp_valid), 1);
    chk("pop_addr", 32'(o_hmp_addr), 32'(exp_q.pop_front()));
    edge_step();
    i_hmp_rd = 1'b0;
  endtask

  task automatic do_clr();
    clear_in();
    clr = 1'b1;
    edge_step();
    clr = 1'b0;
    exp_q.delete();
  endtask

  // Port 0 frees cells 0..n-1 through a one-cycle alloc/release pipeline
  task automatic fill(input int n);
    for (int k = 0; k <= n; k++) begin
      clear_in();
      if (k < n) set_alloc(k, 1);
      if (k > 0) req(0, k - 1);
      mid();
      if (k > 0) chk("fill_ack", 32'(o_rel_ack), 1);
      edge_step();
      if (k > 0) exp_q.push_back(AW'(k - 1));
    end
    clear_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_in();
    clr = 1'b1;
    edge_step();
    req(0, 5);
    mid();
    chk("ack_in_clr", 32'(o_rel_ack), 0);
    edge_step();
    chk("rst_valid", 32'(o_hmp_valid), 0);
    chk("rst_addr", 32'(o_hmp_addr), 0);
    chk("rst_flag", 32'(o_bf_free_flag), 0);
    chk("rst_cnt", 32'(o_free_cnt), 0);
    chk("rst_err", 32'(o_err), 0);
    clr = 1'b0;
    clear_in();

    // 1: two-reader cell
    alloc(5, 4'b0011);
    req(0, 5);
    mid();
    chk("t1_ack0", 32'(o_rel_ack), 4'b0001);
    chk("t1_err0", 32'(o_err), 0);
    edge_step();
    clear_in();
    chk("t1_flag0", 32'(o_bf_free_flag), 0);
    chk("t1_cnt0", 32'(o_free_cnt), 0);
    req(1, 5);
    mid();
    chk("t1_ack1", 32'(o_rel_ack), 4'b0010);
    edge_step();
    clear_in();
    exp_q.push_back(AW'(5));
    chk("t1_flag1", 32'(o_bf_free_flag), 1);
    chk("t1_valid", 32'(o_hmp_valid), 1);
    chk("t1_addr", 32'(o_hmp_addr), 5);
    chk("t1_cnt1", 32'(o_free_cnt), 32'(exp_q.size()));
    pop_chk();
    chk("t1_empty", 32'(o_hmp_valid), 0);

    // 2: round-robin order
    do_clr();
    for (int p = 0; p < MW; p++) alloc(10 + p, 1 << p);
    for (int p = 0; p < MW; p++) req(p, 10 + p);
    for (int k = 0; k < MW; k++) begin
      mid();
      chk("t2_rr_ack", 32'(o_rel_ack), 1 << k);
      edge_step();
      i_rel_req[k] = 1'b0;
      exp_q.push_back(AW'(10 + k));
      chk("t2_flag", 32'(o_bf_free_flag), 1);
    end
    clear_in();
    alloc(14, 4'b0100);
    alloc(15, 4'b1000);
    alloc(16, 4'b0001);
    req(2, 14);
    mid();
    chk("t2_ack2", 32'(o_rel_ack), 4'b0100);
    edge_step();
    clear_in();
    exp_q.push_back(AW'(14));
    req(3, 15);
    req(0, 16);
    mid();
    chk("t2_ptr3", 32'(o_rel_ack), 4'b1000);
    edge_step();
    i_rel_req[3] = 1'b0;
    exp_q.push_back(AW'(15));
    mid();
    chk("t2_ack0", 32'(o_rel_ack), 4'b0001);
    edge_step();
    clear_in();
    exp_q.push_back(AW'(16));
    chk("t2_cnt", 32'(o_free_cnt), 7);
    while (exp_q.size() > 0) pop_chk();
    chk("t2_empty", 32'(o_hmp_valid), 0);

    // 3: four readers, one push
    alloc(9, 4'b1111);
    for (int k = MW - 1; k >= 0; k--) begin
      req(k, 9);
      mid();
      chk("t3_ack", 32'(o_rel_ack), 1 << k);
      edge_step();
      clear_in();
      chk("t3_flag", 32'(o_bf_free_flag), (k == 0) ? 1 : 0);
    end
    exp_q.push_back(AW'(9));
    edge_step();
    chk("t3_flag_once", 32'(o_bf_free_flag), 0);
    chk("t3_cnt", 32'(o_free_cnt), 32'(exp_q.size()));

    // 4: double release by port 1
    alloc(9, 4'b0011);
    req(1, 9);
    mid();
    chk("t4_ack_a", 32'(o_rel_ack), 4'b0010);
    chk("t4_err_a", 32'(o_err), 0);
    edge_step();
    clear_in();
    req(1, 9);
    mid();
    chk("t4_ack_b", 32'(o_rel_ack), 4'b0010);
    chk("t4_err_b", 32'(o_err), 1);
    edge_step();
    clear_in();
    chk("t4_flag", 32'(o_bf_free_flag), 0);
    chk("t4_cnt", 32'(o_free_cnt), 32'(exp_q.size()));

    // 5: full FIFO
    do_clr();
    fill(1 << AW);
    chk("t5_full", 32'(o_free_cnt), 128);
    alloc(0, 1);
    req(0, 0);
    i_hmp_rd = 1'b1;
    mid();
    chk("t5_ack", 32'(o_rel_ack), 1);
    chk("t5_pp_addr", 32'(o_hmp_addr), 32'(exp_q.pop_front()));
    chk("t5_pp_err", 32'(o_err), 0);
    edge_step();
    clear_in();
    exp_q.push_back(AW'(0));
    chk("t5_pp_cnt", 32'(o_free_cnt), 128);
    while (exp_q.size() > 0) pop_chk();
    chk("t5_valid", 32'(o_hmp_valid), 0);
    chk("t5_cnt0", 32'(o_free_cnt), 0);
    i_hmp_rd = 1'b1;
    mid();
    chk("t5_pop_empty_err", 32'(o_err), 1);
    edge_step();
    clear_in();
    chk("t5_cnt_after", 32'(o_free_cnt), 0);

    // 6: clr with pending requests
    do_clr();
    fill(10);
    chk("t6_cnt10", 32'(o_free_cnt), 10);
    clr = 1'b1;
    req(0, 30);
    req(2, 30);
    req(3, 30);
    mid();
    chk("t6_ack_clr", 32'(o_rel_ack), 0);
    chk("t6_err_clr", 32'(o_err), 0);
    edge_step();
    exp_q.delete();
    chk("t6_cnt", 32'(o_free_cnt), 0);
    chk("t6_valid", 32'(o_hmp_valid), 0);
    clr = 1'b0;
    mid();
    chk("t6_ack0", 32'(o_rel_ack), 4'b0001);
    chk("t6_err0", 32'(o_err), 1);
    edge_step();
    i_rel_req[0] = 1'b0;
    mid();
    chk("t6_ack2", 32'(o_rel_ack), 4'b0100);
    edge_step();
    i_rel_req[2] = 1'b0;
    mid();
    chk("t6_ack3", 32'(o_rel_ack), 4'b1000);
    edge_step();
    clear_in();
    chk("t6_cnt_end", 32'(o_free_cnt), 0);

    // 7: alloc errors and same-cell alloc/release
    set_alloc(40, 0);
    mid();
    chk("t7_mcast0_err", 32'(o_err), 1);
    edge_step();
    clear_in();
    alloc(40, 4'b0001);
    set_alloc(40, 4'b0010);
    mid();
    chk("t7_overwrite_err", 32'(o_err), 1);
    edge_step();
    clear_in();
    alloc(41, 4'b0010);
    set_alloc(41, 4'b0100);
    req(1, 41);
    mid();
    chk("t7_col_ack", 32'(o_rel_ack), 4'b0010);
    chk("t7_col_err", 32'(o_err), 1);
    edge_step();
    clear_in();
    chk("t7_col_flag", 32'(o_bf_free_flag), 0);
    chk("t7_col_cnt", 32'(o_free_cnt), 32'(exp_q.size()));
    req(2, 41);
    mid();
    chk("t7_rel_ack", 32'(o_rel_ack), 4'b0100);
    chk("t7_rel_err", 32'(o_err), 0);
    edge_step();
    clear_in();
    exp_q.push_back(AW'(41));
    chk("t7_rel_flag", 32'(o_bf_free_flag), 1);
    pop_chk();
    chk("t7_empty", 32'(o_free_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
